// File: rtl/bus_arbiter4_pkg.sv
// bus_arbiter4_pkg: shared state encodings and width constants for the operand-bus arbiter
package bus_arbiter4_pkg;
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 4;
endpackage

// File: rtl/bus_arbiter4_if.sv
// bus_arbiter4_if: requester-side request/data bundle and the arbitrated operand bus
interface bus_arbiter4_if import bus_arbiter4_pkg::*; #(
    parameter int WIDTH = DATA_W
);
    logic [3:0]       req;
    logic [WIDTH-1:0] A, B, C, D;
    logic [3:0]       gnt;
    logic [1:0]       sw;
    logic [WIDTH-1:0] bus_out;
    logic             bus_valid;
    modport master (output req, A, B, C, D, input gnt, sw, bus_out, bus_valid);
    modport slave  (input req, A, B, C, D, output gnt, sw, bus_out, bus_valid);
endinterface

// File: rtl/bus_arbiter4_mux4x1.sv
// bus_arbiter4_mux4x1: 4:1 operand mux feeding the shared bus register
module bus_arbiter4_mux4x1 import bus_arbiter4_pkg::*; #(
    parameter int WIDTH = DATA_W
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);
    assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter with hold limit driving the registered shared operand bus
module bus_arbiter4 import bus_arbiter4_pkg::*; #(
    parameter int WIDTH    = DATA_W,
    parameter int MAX_HOLD = 4
) (
    input logic           clk,
    input logic           rst,
    bus_arbiter4_if.slave bus
);
    state_t           state;
    logic [3:0]       gnt, others;
    logic [1:0]       sw, last, nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [WIDTH-1:0] bus_out, mux_y;
    logic             bus_valid, owner_req, at_max, go;

    // first set bit searching last+1, last+2, last+3, last
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] w, idx;
        w = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign owner_req = bus.req[sw];
    assign others    = bus.req & ~(4'b1 << sw);
    assign at_max    = hold_cnt == CNT_W'(MAX_HOLD);

    always_comb begin
        go  = state == STATE_BUSY ? (!owner_req || at_max) && |others : |bus.req;
        nxt = rr_pick(state == STATE_BUSY ? others : bus.req, last);
    end

    bus_arbiter4_mux4x1 #(.WIDTH(WIDTH)) u_mux (
        .sel(sw),
        .a(bus.A),
        .b(bus.B),
        .c(bus.C),
        .d(bus.D),
        .y(mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STATE_IDLE;
            gnt       <= '0;
            sw        <= '0;
            last      <= 2'd3;
            hold_cnt  <= '0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
        end else begin
            bus_valid <= state == STATE_BUSY && owner_req;
            if (state == STATE_BUSY && owner_req) bus_out <= mux_y;
            if (go) begin
                gnt      <= 4'b1 << nxt;
                sw       <= nxt;
                last     <= nxt;
                hold_cnt <= CNT_W'(1);
                state    <= STATE_BUSY;
            end else if (state == STATE_BUSY) begin
                if (!owner_req) begin
                    gnt   <= '0;
                    state <= STATE_IDLE;
                end else begin
                    hold_cnt <= at_max ? CNT_W'(1) : hold_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.sw        = sw;
    assign bus.bus_out   = bus_out;
    assign bus.bus_valid = bus_valid;
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed and random stimulus on MAX_HOLD=4 and MAX_HOLD=1 arbiters vs a behavioural model
module tb_bus_arbiter4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    bus_arbiter4_if #(.WIDTH(10)) if4 ();
    bus_arbiter4_if #(.WIDTH(10)) if1 ();

    bus_arbiter4 #(.WIDTH(10), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    bus_arbiter4 #(.WIDTH(10), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    int         owner[2];
    int         last[2];
    int         held[2];
    int         mh[2] = '{4, 1};
    logic [3:0] egnt[2];
    logic [1:0] esw[2];
    logic [9:0] ebus[2];
    logic       ev[2];
    logic [3:0][9:0] dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] m, input int l);
        for (int k = 1; k <= 4; k++)
            if (m[(l + k) % 4]) return (l + k) % 4;
        return -1;
    endfunction

    task automatic grant(input int i, input int w);
        owner[i] = w;
        last[i]  = w;
        held[i]  = 1;
        egnt[i]  = 4'b1 << w;
        esw[i]   = 2'(w);
    endtask

    // one rising edge of the reference arbiter i with inputs r, q and current data
    task automatic mstep(input int i, input logic r, input logic [3:0] q);
        logic [3:0] oth;
        if (r) begin
            owner[i] = -1; last[i] = 3; held[i] = 0;
            egnt[i] = '0; esw[i] = '0; ebus[i] = '0; ev[i] = 1'b0;
            return;
        end
        ev[i] = owner[i] >= 0 && q[owner[i]];
        if (ev[i]) ebus[i] = dat[owner[i]];
        if (owner[i] < 0) begin
            if (q != 0) grant(i, pick(q, last[i]));
            return;
        end
        oth = q;
        oth[owner[i]] = 1'b0;
        if (!q[owner[i]]) begin
            if (oth != 0) grant(i, pick(oth, last[i]));
            else begin
                owner[i] = -1;
                egnt[i] = '0;
            end
        end else if (held[i] == mh[i]) begin
            if (oth != 0) grant(i, pick(oth, last[i]));
            else held[i] = 1;
        end else held[i]++;
    endtask

    task automatic check_all();
        chk("gnt4", 32'(if4.gnt), 32'(egnt[0]));
        chk("sw4", 32'(if4.sw), 32'(esw[0]));
        chk("bus4", 32'(if4.bus_out), 32'(ebus[0]));
        chk("valid4", 32'(if4.bus_valid), 32'(ev[0]));
        chk("gnt1", 32'(if1.gnt), 32'(egnt[1]));
        chk("sw1", 32'(if1.sw), 32'(esw[1]));
        chk("bus1", 32'(if1.bus_out), 32'(ebus[1]));
        chk("valid1", 32'(if1.bus_valid), 32'(ev[1]));
    endtask

    task automatic apply(input logic r, input logic [3:0] q);
        rst = r;
        if4.req = q; if1.req = q;
        {if4.D, if4.C, if4.B, if4.A} = dat;
        {if1.D, if1.C, if1.B, if1.A} = dat;
        mstep(0, r, q);
        mstep(1, r, q);
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_all();
            apply(r, q);
        end
    endtask

    initial begin
        logic [3:0] rq;
        dat = '0;
        apply(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 2);
        dat[0] = 10'h001;
        cyc(1'b0, 4'b0001, 3);
        cyc(1'b0, 4'b0000, 2);
        dat = {10'h003, 10'h002, 10'h007, 10'h001};
        cyc(1'b0, 4'b1111, 16);
        cyc(1'b0, 4'b0000, 2);
        cyc(1'b0, 4'b0010, 2);
        cyc(1'b0, 4'b0110, 2);
        cyc(1'b0, 4'b0100, 2);
        cyc(1'b0, 4'b1000, 10);
        cyc(1'b0, 4'b1111, 10);
        cyc(1'b1, 4'b1111, 1);
        cyc(1'b0, 4'b1111, 4);
        cyc(1'b0, 4'b0101, 6);
        rq = 4'b0000;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) dat[k] = 10'($urandom);
            cyc($urandom_range(0, 59) == 0, rq, 1);
        end
        @(negedge clk);
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
